// File: rtl/ln_pkg.sv
// Shared definitions for the ln(x+1) Maclaurin unit.
// Holds the control FSM states and the term-count constants.
package ln_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        INIT  = 3'd2,
        MUL_X = 3'd3,
        MUL_C = 3'd4,
        ACC   = 3'd5,
        DONE  = 3'd6
    } lnState_t;

    localparam int ITER_LIMIT_DEF = 8;
    localparam int TERM_COUNT     = 8;

endpackage

// File: rtl/ln_cu.sv
// Control unit for the ln(x+1) datapath.
// Sequences the term loop and guards it with an iteration watchdog.
module ln_cu
    import ln_pkg::*;
#(
    parameter int ITER_LIMIT = ITER_LIMIT_DEF,
    parameter int IW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ack,
    input  logic          cnt8,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          init0,
    output logic          cntUp,
    output logic          ldX,
    output logic          initT1,
    output logic          ldT,
    output logic          initLN1,
    output logic          ldLN,
    output logic          selXR,
    output logic [IW-1:0] iter
);

    localparam logic [IW-1:0] LIMIT = IW'(ITER_LIMIT);

    lnState_t      state;
    lnState_t      stateNext;
    logic          iterClr;
    logic          iterInc;
    logic          errSet;
    logic [IW-1:0] iterPlus;
    logic          lastIter;

    assign iterPlus = iter + 1'b1;
    assign lastIter = (iterPlus == LIMIT);

    // State register; reset abandons any run in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Iteration count saturates at the limit; err latches the watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter <= '0;
            err  <= 1'b0;
        end else if (iterClr) begin
            iter <= '0;
            err  <= 1'b0;
        end else begin
            if (iterInc && (iter != LIMIT)) begin
                iter <= iterPlus;
            end
            if (errSet) begin
                err <= 1'b1;
            end
        end
    end

    // Next state and strobe decode, all strobes default low.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        init0     = 1'b0;
        cntUp     = 1'b0;
        ldX       = 1'b0;
        initT1    = 1'b0;
        ldT       = 1'b0;
        initLN1   = 1'b0;
        ldLN      = 1'b0;
        selXR     = 1'b0;
        iterClr   = 1'b0;
        iterInc   = 1'b0;
        errSet    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = LOAD;
                    iterClr   = 1'b1;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                init0     = 1'b1;
                ldX       = 1'b1;
                initT1    = 1'b1;
                stateNext = INIT;
            end
            INIT: begin
                busy      = 1'b1;
                initLN1   = 1'b1;
                stateNext = MUL_X;
            end
            MUL_X: begin
                busy      = 1'b1;
                ldT       = 1'b1;
                selXR     = 1'b1;
                stateNext = MUL_C;
            end
            MUL_C: begin
                busy      = 1'b1;
                ldT       = 1'b1;
                stateNext = ACC;
            end
            ACC: begin
                busy    = 1'b1;
                ldLN    = 1'b1;
                iterInc = 1'b1;
                if (cnt8) begin
                    stateNext = DONE;
                end else if (lastIter) begin
                    stateNext = DONE;
                    errSet    = 1'b1;
                end else begin
                    stateNext = MUL_X;
                    cntUp     = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    stateNext = LOAD;
                    iterClr   = 1'b1;
                end else if (ack) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
